// File: rtl/sram_pkg.sv
// Shared definitions for the sram read-side stream master: default widths,
// the reader FSM state type and the issue-credit helper.
package sram_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 32;

  // Output buffer depth; the credit check below is written for this depth.
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;

  // A new read may be issued only if every word that is buffered or on its
  // way back from the sram, minus the word leaving this cycle, still leaves
  // room for it in the FIFO.
  function automatic logic credit_ok(input logic [1:0] fifo_cnt,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] occ;
    logic [2:0] room;
    occ  = {1'b0, fifo_cnt} + {2'b00, inflight};
    room = 3'(FIFO_DEPTH) + {2'b00, pop};
    return occ < room;
  endfunction

endpackage

// File: rtl/sram_stream_reader_if.sv
// Output word stream of the sram reader.
//
// Handshake: a word transfers on a rising clock edge where m_valid and
// m_ready are both 1. Once m_valid is raised, m_valid and m_data stay
// unchanged until that transfer; m_valid never depends on m_ready, while
// the consumer may drive m_ready freely.
interface sram_stream_reader_if #(
  parameter int DW = 32
) ();
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/sram_rd_fifo.sv
// Two-entry synchronous FIFO that buffers words returned by the sram.
// Push and pop may happen in the same cycle, including when full.
module sram_rd_fifo #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    count,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage and write pointer; entries clear on reset so the head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= ~wr_ptr;
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
    end else if (do_pop) begin
      rd_ptr <= ~rd_ptr;
    end
  end

  // Occupancy tracks the net effect of push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Burst read master for the sram: reads len words starting at base_adr
// (wrapping modulo 2^AW) and streams them out with full backpressure.
// The sram answers one cycle after it samples adr, so at most one read is
// outstanding; issue is throttled so buffered plus in-flight words never
// exceed the two FIFO entries.
module sram_stream_reader
  import sram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_adr,
  input  logic [AW:0]         len,
  output logic                busy,
  output logic                done,
  output logic                nWE,
  output logic [AW-1:0]       adr,
  input  logic [DW-1:0]       sram_dout,
  sram_stream_reader_if.master m,
  output rd_state_t           state_dbg
);

  localparam logic [AW:0] CNT_ZERO = '0;
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  rd_state_t     state;
  rd_state_t     state_nx;
  logic [AW:0]   issue_cnt;
  logic [AW:0]   rcv_cnt;
  logic          inflight;
  logic          issue;
  logic          load;
  logic          pop;
  logic [1:0]    fifo_cnt;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;

  // The reader never writes the sram.
  assign nWE       = 1'b1;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign state_dbg = state;

  assign m.m_valid = !fifo_empty;
  assign m.m_data  = fifo_head;
  assign pop       = m.m_valid && m.m_ready;

  // One read per cycle while words remain and the buffer has credit.
  assign issue = (state == READ) && (issue_cnt != CNT_ZERO) &&
                 credit_ok(fifo_cnt, inflight, pop);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; load marks the cycle a burst request is accepted.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == CNT_ZERO) begin
            state_nx = FINISH;
          end else begin
            state_nx = READ;
            load     = 1'b1;
          end
        end
      end
      READ: begin
        if (issue && (issue_cnt == CNT_ONE)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if ((rcv_cnt == CNT_ZERO) || (pop && (rcv_cnt == CNT_ONE))) begin
          state_nx = FINISH;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Address register and remaining-issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr       <= '0;
      issue_cnt <= '0;
    end else if (load) begin
      adr       <= base_adr;
      issue_cnt <= len;
    end else if (issue) begin
      adr       <= adr + 1'b1;
      issue_cnt <= issue_cnt - CNT_ONE;
    end
  end

  // Words still owed to the consumer; drops on every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcv_cnt <= '0;
    end else if (load) begin
      rcv_cnt <= len;
    end else if (pop && (rcv_cnt != CNT_ZERO)) begin
      rcv_cnt <= rcv_cnt - CNT_ONE;
    end
  end

  // A read issued this cycle returns data to be captured next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
    end
  end

  sram_rd_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (sram_dout),
    .dout  (fifo_head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: an sram model preloaded with 0x1000+i,
// a queue of expected words per burst derived from base/len, and a
// per-cycle compare process for order, stability and the write enable.
module tb_sram_stream_reader;
  import sram_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;

  // Clock / reset / DUT signals
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_adr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          nWE;
  logic [AW-1:0] adr;
  logic [DW-1:0] sram_dout;
  rd_state_t     state_dbg;

  sram_stream_reader_if #(.DW(DW)) sif ();

  always #5 clk = ~clk;

  sram_stream_reader #(
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .nWE       (nWE),
    .adr       (adr),
    .sram_dout (sram_dout),
    .m         (sif),
    .state_dbg (state_dbg)
  );

  // sram read model: adr sampled at an edge, data valid after that edge.
  logic [DW-1:0] mem [64];
  always @(posedge clk) sram_dout <= mem[adr];

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            hs_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] last_adr;
  bit            stall_pend = 1'b0;
  logic [DW-1:0] held;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: evaluated mid-cycle, so a valid&ready seen here is the
  // handshake that completes at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      chk("nwe_high", longint'(nWE), 1);
      chk("fifo_le_2", longint'(dut.u_fifo.count <= 2'd2), 1);
      if (stall_pend) begin
        chk("valid_held", longint'(sif.m_valid), 1);
        chk("data_held", longint'(sif.m_data), longint'(held));
      end
      if (sif.m_valid && exp_q.size() == 0) begin
        chk("unexpected_valid", longint'(sif.m_valid), 0);
      end else if (sif.m_valid && sif.m_ready) begin
        chk("stream_data", longint'(sif.m_data), longint'(exp_q.pop_front()));
        hs_cnt++;
      end
      stall_pend = sif.m_valid && !sif.m_ready;
      held       = sif.m_data;
      if (done) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_nwe"}, longint'(nWE), 1);
    chk({tag, "_adr"}, longint'(adr), 0);
    chk({tag, "_valid"}, longint'(sif.m_valid), 0);
    chk({tag, "_data"}, longint'(sif.m_data), 0);
    chk({tag, "_state"}, longint'(state_dbg), longint'(IDLE));
  endtask

  // Driver: one burst. mode 0 = m_ready held 1; mode 1 = alternating with a
  // 5-cycle stall. bad_at: cycle on which a stray start is pulsed.
  // abort_hs: assert reset once that many words have handshaked.
  // exp_cycles: edges from the start edge to the done cycle (-1 = skip).
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l,
                           input int mode, input int bad_at, input int abort_hs,
                           input bit fin_start, input logic [DW-1:0] first_lit,
                           input int exp_cycles);
    int cycles;
    int hs0;
    int dn0;
    bit seen_first;
    bit aborted;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[(int'(b) + i) % 64]);
    hs0 = hs_cnt;
    dn0 = done_cnt;
    base_adr = b;
    len = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_adr = 6'd33;
    len = 7'd5;
    if (l != 0) begin
      chk("busy_after_start", longint'(busy), 1);
      chk("adr_after_start", longint'(adr), longint'(b));
    end else begin
      chk("adr_unchanged", longint'(adr), longint'(last_adr));
    end
    cycles = 0;
    seen_first = 1'b0;
    aborted = 1'b0;
    while (!done && cycles < 400) begin
      if (mode == 1) sif.m_ready = (cycles >= 12 && cycles < 17) ? 1'b0 : (cycles % 2 == 0);
      else sif.m_ready = 1'b1;
      if (cycles == bad_at) begin
        start = 1'b1;
        base_adr = 6'd40;
        len = 7'd20;
      end
      @(posedge clk);
      cycles++;
      #1;
      start = 1'b0;
      if (sif.m_valid && !seen_first) begin
        seen_first = 1'b1;
        chk("first_word", longint'(sif.m_data), longint'(first_lit));
        if (mode == 0) chk("first_latency", cycles, 2);
      end
      if (abort_hs > 0 && (hs_cnt - hs0) >= abort_hs) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        aborted = 1'b1;
        break;
      end
    end
    sif.m_ready = 1'b1;
    if (aborted) begin
      exp_q.delete();
      last_adr = '0;
    end else begin
      if (cycles >= 400) chk("done_timeout", 0, 1);
      if (exp_cycles >= 0) chk("done_cycles", cycles, exp_cycles);
      if (fin_start) begin
        start = 1'b1;
        base_adr = 6'd0;
        len = 7'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_done", longint'(busy), 0);
      chk("done_one_cycle", longint'(done), 0);
      chk("done_pulses", done_cnt - dn0, 1);
      chk("word_count", hs_cnt - hs0, int'(l));
      chk("leftover", exp_q.size(), 0);
      last_adr = b + l[AW-1:0];
    end
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    rst = 1'b1;
    start = 1'b0;
    base_adr = '0;
    len = '0;
    sif.m_ready = 1'b1;
    last_adr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-rate burst: 24 words, last handshake 26 edges after start.
    run_burst(6'd0, 7'd24, 0, -1, 0, 1'b0, 32'h1000, 26);
    // Address wrap 62,63,0,1; a start during FINISH must be ignored.
    run_burst(6'd62, 7'd4, 0, -1, 0, 1'b1, 32'h103E, 6);
    // Backpressure: alternating ready plus a 5-cycle stall.
    run_burst(6'd0, 7'd24, 1, -1, 0, 1'b0, 32'h1000, -1);
    // Zero-length: done right after the start edge, no data.
    run_burst(6'd17, 7'd0, 0, -1, 0, 1'b0, 32'h0, 0);
    // Stray start mid-burst is ignored: exactly 8 words from 10.
    run_burst(6'd10, 7'd8, 0, 3, 0, 1'b0, 32'h100A, 10);
    // Reset after the 5th word of a 16-word burst.
    dn = done_cnt;
    run_burst(6'd0, 7'd16, 0, -1, 5, 1'b0, 32'h1000, -1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - dn, 0);
    chk("idle_after_abort", longint'(busy), 0);
    // Fresh burst after the abort.
    run_burst(6'd5, 7'd16, 0, -1, 0, 1'b0, 32'h1005, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
